lu_serial_ctrl: RTL and testbench
=================================

LU_SERIAL_CTRL -- requirements
Module: lu_serial_ctrl

Interface
REQ-001 Parameter: WIDTH, default 8, operand/result width in bits (WIDTH >= 1).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 in_valid  input  1  operand word and op code presented.
REQ-005 in_ready  output  1  block accepts a new operation this cycle.
REQ-006 op_a  input  WIDTH  operand A.
REQ-007 op_b  input  WIDTH  operand B.
REQ-008 op_sel  input  2  op code: bit1 selects group, bit0 selects op. 00 NAND, 01 AND, 10 NOR, 11 OR.
REQ-009 lu_a  output  1  current A bit to the downstream 1-bit logic unit.
REQ-010 lu_b  output  1  current B bit to the logic unit.
REQ-011 lu_select_op  output  1  op_sel[0] latched at accept.
REQ-012 lu_select_group  output  1  op_sel[1] latched at accept.
REQ-013 lu_out  input  1  combinational result bit returned by the logic unit in the same cycle.
REQ-014 res_valid  output  1  res_data holds a complete result.
REQ-015 res_ready  input  1  consumer accepts res_data.
REQ-016 res_data  output  WIDTH  assembled result word, bit i = LU(op_a[i], op_b[i]).
REQ-017 busy  output  1  high whenever state is not IDLE.

Function
REQ-018 FSM states: IDLE, SHIFT, DONE.
REQ-019 IDLE: in_ready=1; in_valid=1 at a rising edge latches op_a, op_b, op_sel, clears bit counter, moves to SHIFT.
REQ-020 in_ready SHALL be 0 in SHIFT and DONE; in_valid there is ignored and no operand is latched.
REQ-021 SHIFT: lu_a/lu_b drive the LSB of the internal A/B shift registers; each edge captures lu_out into the result MSB, shifts the result register right one bit, shifts A/B right, increments counter.
REQ-022 Bits are serialised LSB first; after WIDTH SHIFT cycles bit i of the result equals lu_out sampled for operand bit i.
REQ-023 On the edge where counter = WIDTH-1, the FSM moves to DONE; res_valid rises on the WIDTH-th rising edge after the accepting edge.
REQ-024 Counter width: ceil(log2(WIDTH)), minimum 1 bit; counter never wraps within one operation.
REQ-025 DONE: res_valid=1, res_data stable; res_ready=1 at an edge returns to IDLE; res_ready=0 holds DONE and res_data indefinitely.
REQ-026 lu_a, lu_b SHALL be 0 outside SHIFT; lu_select_* keep their latched values until the next accept.
REQ-027 Changes to op_a/op_b/op_sel after accept SHALL NOT affect the operation in progress.
REQ-028 WIDTH=1: exactly one SHIFT cycle, then DONE.

Reset
REQ-029 rst=1 forces IDLE immediately, independent of clk; clears A/B/result registers, counter, latched op code.
REQ-030 Output values under reset: in_ready=1, busy=0, res_valid=0, res_data=0, lu_a=lu_b=lu_select_op=lu_select_group=0.
REQ-031 Reset during SHIFT or DONE discards the operation; no res_valid follows.

Structure
REQ-032 Shared package lu_pkg holds the FSM state enum and op-code constants OP_NAND=00, OP_AND=01, OP_NOR=10, OP_OR=11.
REQ-033 One sub-module, bit_shifter: WIDTH-bit right-shift register with load, shift, and serial-in, instantiated for A, B, and result.
REQ-034 The 1-bit logic unit is external; lu_serial_ctrl contains no logic-function gates.

Verification
REQ-035 Bench connects a behavioural 1-bit logic-unit model to the lu_* ports.
REQ-036 op_a=A5, op_b=0F, op_sel=01 -> res_valid after 8 edges, res_data=05.
REQ-037 Same operands, op_sel=11 -> AF; op_sel=00 -> FA; op_sel=10 -> 50.
REQ-038 res_ready held 0 for 5 cycles in DONE -> res_data=AF stable, in_ready=0; new in_valid ignored until return to IDLE.
REQ-039 Pulse rst at SHIFT cycle 3 -> immediate IDLE, in_ready=1, res_valid never asserts; next op A5/0F AND -> 05.
REQ-040 Change op_a/op_sel mid-SHIFT -> result equals the latched operation only.

Source files
------------

// File: rtl/lu_pkg.sv
// Shared definitions for the serial logic-unit controller: FSM states,
// op-code constants and the bit-counter sizing helper.
package lu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // op_sel[1] picks the group (AND-type / OR-type), op_sel[0] picks plain vs inverted.
  localparam logic [1:0] OP_NAND = 2'b00;
  localparam logic [1:0] OP_AND  = 2'b01;
  localparam logic [1:0] OP_NOR  = 2'b10;
  localparam logic [1:0] OP_OR   = 2'b11;

  // ceil(log2(width)) with a floor of one bit so WIDTH=1 still has a counter.
  function automatic int cnt_bits(input int width);
    if (width <= 2) return 1;
    return $clog2(width);
  endfunction

endpackage

// File: rtl/lu_serial_ctrl_bit_shifter.sv
// WIDTH-bit right-shift register with parallel load and serial input at the MSB.
// Load has priority over shift.
module bit_shifter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_data_i,
  input  logic             shift_i,
  input  logic             ser_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;
  logic [WIDTH-1:0] shifted;

  generate
    if (WIDTH == 1) begin : g_one
      assign shifted = ser_i;
    end else begin : g_multi
      assign shifted = {ser_i, q_q[WIDTH-1:1]};
    end
  endgenerate

  always_comb begin
    q_d = q_q;
    if (load_i) begin
      q_d = load_data_i;
    end else if (shift_i) begin
      q_d = shifted;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/lu_serial_ctrl.sv
// Serialises two operand words LSB-first through an external 1-bit logic unit
// and reassembles the returned bits into a result word.
module lu_serial_ctrl
  import lu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic [1:0]       op_sel,
  output logic             lu_a,
  output logic             lu_b,
  output logic             lu_select_op,
  output logic             lu_select_group,
  input  logic             lu_out,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic             busy,
  output logic [1:0]       dbg_state_o
);

  localparam int             CW   = cnt_bits(WIDTH);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          sel_op_q, sel_op_d;
  logic          sel_grp_q, sel_grp_d;
  logic          accept;
  logic          shifting;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] res_q;

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; in_ready is high only in IDLE, res_valid only in DONE, and
  // res_valid/res_data hold until res_ready is seen at an edge.
  assign accept   = (state_q == ST_IDLE) && in_valid;
  assign shifting = (state_q == ST_SHIFT);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sel_op_d  = sel_op_q;
    sel_grp_d = sel_grp_q;
    in_ready  = 1'b0;
    busy      = 1'b1;
    res_valid = 1'b0;
    lu_a      = 1'b0;
    lu_b      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) begin
          state_d   = ST_SHIFT;
          cnt_d     = '0;
          sel_op_d  = op_sel[0];
          sel_grp_d = op_sel[1];
        end
      end
      ST_SHIFT: begin
        lu_a = a_q[0];
        lu_b = b_q[0];
        // Stop incrementing on the last bit so the counter never wraps.
        if (cnt_q == LAST) begin
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_DONE: begin
        res_valid = 1'b1;
        if (res_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      sel_op_q  <= 1'b0;
      sel_grp_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sel_op_q  <= sel_op_d;
      sel_grp_q <= sel_grp_d;
    end
  end

  bit_shifter #(.WIDTH(WIDTH)) u_a_sr (
    .clk         (clk),
    .rst         (rst),
    .load_i      (accept),
    .load_data_i (op_a),
    .shift_i     (shifting),
    .ser_i       (1'b0),
    .q_o         (a_q)
  );

  bit_shifter #(.WIDTH(WIDTH)) u_b_sr (
    .clk         (clk),
    .rst         (rst),
    .load_i      (accept),
    .load_data_i (op_b),
    .shift_i     (shifting),
    .ser_i       (1'b0),
    .q_o         (b_q)
  );

  // Result enters at the MSB; after WIDTH shifts the first bit lands at bit 0.
  bit_shifter #(.WIDTH(WIDTH)) u_res_sr (
    .clk         (clk),
    .rst         (rst),
    .load_i      (accept),
    .load_data_i ({WIDTH{1'b0}}),
    .shift_i     (shifting),
    .ser_i       (lu_out),
    .q_o         (res_q)
  );

  assign res_data        = res_q;
  assign lu_select_op    = sel_op_q;
  assign lu_select_group = sel_grp_q;
  assign dbg_state_o     = state_q;

endmodule

// File: tb/tb_lu_serial_ctrl.sv
// Self-checking bench for lu_serial_ctrl: WIDTH=8 and WIDTH=1 instances, each
// driven by a behavioural 1-bit logic unit, checked against word-level results.
module tb_lu_serial_ctrl;
  import lu_pkg::*;

  localparam int W = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // ---------------- WIDTH=8 DUT ----------------
  logic         in_valid, in_ready;
  logic [W-1:0] op_a, op_b;
  logic [1:0]   op_sel;
  logic         lu_a, lu_b, lu_select_op, lu_select_group, lu_out;
  logic         res_valid, res_ready, busy;
  logic [W-1:0] res_data;
  logic [1:0]   dbg_state;

  // ---------------- WIDTH=1 DUT ----------------
  logic       v1, rdy1, a1, b1, lua1, lub1, lso1, lsg1, luo1, rv1, rr1, busy1;
  logic [1:0] sel1, dbg1;
  logic       rd1;

  int n_checks = 0;
  int n_fail   = 0;
  logic [W-1:0] exp_q[$];

  // Behavioural logic unit: group bit picks AND/OR, op bit picks inverted/plain.
  function automatic logic lu_model(input logic grp, input logic op, input logic a, input logic b);
    case ({grp, op})
      2'b00:   return ~(a & b);
      2'b01:   return a & b;
      2'b10:   return ~(a | b);
      default: return a | b;
    endcase
  endfunction

  function automatic logic [W-1:0] ref_word(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic [1:0] sel);
    case (sel)
      OP_NAND: return ~(a & b);
      OP_AND:  return a & b;
      OP_NOR:  return ~(a | b);
      default: return a | b;
    endcase
  endfunction

  assign lu_out = lu_model(lu_select_group, lu_select_op, lu_a, lu_b);
  assign luo1   = lu_model(lsg1, lso1, lua1, lub1);

  lu_serial_ctrl #(.WIDTH(W)) dut (
    .clk             (clk),
    .rst             (rst),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .op_a            (op_a),
    .op_b            (op_b),
    .op_sel          (op_sel),
    .lu_a            (lu_a),
    .lu_b            (lu_b),
    .lu_select_op    (lu_select_op),
    .lu_select_group (lu_select_group),
    .lu_out          (lu_out),
    .res_valid       (res_valid),
    .res_ready       (res_ready),
    .res_data        (res_data),
    .busy            (busy),
    .dbg_state_o     (dbg_state)
  );

  lu_serial_ctrl #(.WIDTH(1)) dut_w1 (
    .clk             (clk),
    .rst             (rst),
    .in_valid        (v1),
    .in_ready        (rdy1),
    .op_a            (a1),
    .op_b            (b1),
    .op_sel          (sel1),
    .lu_a            (lua1),
    .lu_b            (lub1),
    .lu_select_op    (lso1),
    .lu_select_group (lsg1),
    .lu_out          (luo1),
    .res_valid       (rv1),
    .res_ready       (rr1),
    .res_data        (rd1),
    .busy            (busy1),
    .dbg_state_o     (dbg1)
  );

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] sel,
                        input int hold, input bit scramble);
    logic [W-1:0] got;
    int n;
    @(negedge clk);
    op_a = a; op_b = b; op_sel = sel; in_valid = 1'b1;
    chk("in_ready_idle", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    exp_q.push_back(ref_word(a, b, sel));
    chk("busy_shift", busy, 1);
    chk("sel_latched", {lu_select_group, lu_select_op}, sel);
    n = 0;
    while (!res_valid && n < W + 4) begin
      if (n < W) begin
        chk("lu_a_bit", lu_a, a[n]);
        chk("lu_b_bit", lu_b, b[n]);
      end
      chk("in_ready_shift", in_ready, 0);
      if (scramble) begin
        op_a = W'($urandom); op_b = W'($urandom); op_sel = 2'($urandom);
        in_valid = 1'b1;
      end
      @(posedge clk); #1;
      n++;
    end
    in_valid = 1'b0;
    chk("latency", n, W);
    got = res_data;
    chk("res_data", got, exp_q.pop_front());
    chk("lu_a_done", {lu_a, lu_b}, 0);
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'b1;
      op_a = W'($urandom); op_sel = 2'($urandom);
      @(posedge clk); #1;
      chk("hold_valid", res_valid, 1);
      chk("hold_data", res_data, got);
      chk("hold_in_ready", in_ready, 0);
    end
    in_valid  = 1'b0;
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    chk("back_idle", in_ready, 1);
    chk("valid_dropped", res_valid, 0);
    chk("data_kept", res_data, got);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_in_ready"}, in_ready, 1);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_res_valid"}, res_valid, 0);
    chk({tag, "_res_data"}, res_data, 0);
    chk({tag, "_lu"}, {lu_a, lu_b, lu_select_op, lu_select_group}, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: run did not complete");
    $fatal(1, "timeout");
  end

  // ---------------- main sequence ----------------
  initial begin
    int seen;
    rst = 1'b1; in_valid = 1'b0; op_a = '0; op_b = '0; op_sel = '0; res_ready = 1'b0;
    v1 = 1'b0; a1 = 1'b0; b1 = 1'b0; sel1 = '0; rr1 = 1'b0;
    #1;
    check_reset_outputs("rst_init");
    @(negedge clk);
    rst = 1'b0;

    // Reference vectors
    run_op(8'hA5, 8'h0F, OP_AND,  0, 1'b0);
    run_op(8'hA5, 8'h0F, OP_OR,   5, 1'b0);
    run_op(8'hA5, 8'h0F, OP_NAND, 0, 1'b0);
    run_op(8'hA5, 8'h0F, OP_NOR,  1, 1'b0);

    // Operand and op-code changes after accept must not matter
    run_op(8'h3C, 8'hC3, OP_OR, 0, 1'b1);

    // Asynchronous reset in the middle of SHIFT
    @(negedge clk);
    op_a = 8'hA5; op_b = 8'h0F; op_sel = OP_OR; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    #1 check_reset_outputs("rst_mid");
    chk("rst_mid_state", dbg_state, ST_IDLE);
    #1 rst = 1'b0;
    seen = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (res_valid) seen++;
    end
    chk("no_valid_after_reset", seen, 0);
    run_op(8'hA5, 8'h0F, OP_AND, 0, 1'b0);

    // Random operations
    for (int i = 0; i < 20; i++) begin
      run_op(W'($urandom), W'($urandom), 2'($urandom_range(0, 3)),
             $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    // WIDTH=1 boundary: one SHIFT cycle, then DONE
    for (int i = 0; i < 16; i++) begin
      logic [3:0] v;
      v = 4'(i);
      @(negedge clk);
      a1 = v[0]; b1 = v[1]; sel1 = v[3:2]; v1 = 1'b1;
      @(posedge clk); #1;
      v1 = 1'b0;
      chk("w1_busy", busy1, 1);
      chk("w1_not_done", rv1, 0);
      chk("w1_lu_in", {lua1, lub1}, {v[0], v[1]});
      @(posedge clk); #1;
      chk("w1_valid", rv1, 1);
      chk("w1_data", rd1, lu_model(v[3], v[2], v[0], v[1]));
      rr1 = 1'b1;
      @(posedge clk); #1;
      rr1 = 1'b0;
      chk("w1_idle", rdy1, 1);
    end

    chk("exp_q_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
